// File: rtl/mult_div_unit.sv
// Multiply/divide unit with HI/LO registers.
// Multi-cycle MULT/DIV with busy/stall handshake to the pipeline.
module mult_div_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] srcA,
   input  logic [31:0] srcB,
   input  logic [2:0]  mduOp,
   input  logic        start,
   output logic        busy,
   output logic        stall,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ?
                         MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

   localparam logic [CW-1:0] MULT_LD = CW'(MULT_CYCLES - 1);
   localparam logic [CW-1:0] DIV_LD  = CW'(DIV_CYCLES - 1);

   localparam logic [2:0] OP_MULT  = 3'b001;
   localparam logic [2:0] OP_MULTU = 3'b010;
   localparam logic [2:0] OP_DIV   = 3'b011;
   localparam logic [2:0] OP_DIVU  = 3'b100;
   localparam logic [2:0] OP_MTHI  = 3'b101;
   localparam logic [2:0] OP_MTLO  = 3'b110;

   typedef enum logic {IDLE, RUN} state_e;

   state_e        state_q;
   logic [CW-1:0] cnt_q;
   logic [2:0]    op_q;
   logic [31:0]   a_q;
   logic [31:0]   b_q;
   logic [31:0]   hi_q;
   logic [31:0]   lo_q;
   logic          busy_q;

   logic [63:0] a_sx;
   logic [63:0] b_sx;
   logic [63:0] smul;
   logic [63:0] umul;
   logic [31:0] a_abs;
   logic [31:0] b_abs;
   logic [31:0] b_safe;
   logic [31:0] babs_safe;
   logic [31:0] uq;
   logic [31:0] ur;
   logic [31:0] sq_abs;
   logic [31:0] sr_abs;
   logic [31:0] hi_d;
   logic [31:0] lo_d;

   // Products and quotients from the latched operands.
   // Signed division works on magnitudes so that
   // 0x80000000 / -1 naturally yields 0x80000000 rem 0.
   always_comb begin
      a_sx      = {{32{a_q[31]}}, a_q};
      b_sx      = {{32{b_q[31]}}, b_q};
      smul      = a_sx * b_sx;
      umul      = {32'd0, a_q} * {32'd0, b_q};
      a_abs     = a_q[31] ? (~a_q + 32'd1) : a_q;
      b_abs     = b_q[31] ? (~b_q + 32'd1) : b_q;
      b_safe    = (b_q == 32'd0) ? 32'd1 : b_q;
      babs_safe = (b_q == 32'd0) ? 32'd1 : b_abs;
      uq        = a_q / b_safe;
      ur        = a_q % b_safe;
      sq_abs    = a_abs / babs_safe;
      sr_abs    = a_abs % babs_safe;
   end

   // Select the HI/LO values written at completion.
   // A zero divisor leaves HI/LO untouched.
   always_comb begin
      hi_d = hi_q;
      lo_d = lo_q;
      case (op_q)
         OP_MULT: begin
            hi_d = smul[63:32];
            lo_d = smul[31:0];
         end
         OP_MULTU: begin
            hi_d = umul[63:32];
            lo_d = umul[31:0];
         end
         OP_DIV: begin
            if (b_q != 32'd0) begin
               lo_d = (a_q[31] ^ b_q[31]) ?
                      (~sq_abs + 32'd1) : sq_abs;
               hi_d = a_q[31] ?
                      (~sr_abs + 32'd1) : sr_abs;
            end
         end
         OP_DIVU: begin
            if (b_q != 32'd0) begin
               lo_d = uq;
               hi_d = ur;
            end
         end
         default: begin
            hi_d = hi_q;
            lo_d = lo_q;
         end
      endcase
   end

   // Control FSM: accept requests in IDLE, count down in RUN.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  case (mduOp)
                     OP_MULT, OP_MULTU: begin
                        op_q    <= mduOp;
                        a_q     <= srcA;
                        b_q     <= srcB;
                        cnt_q   <= MULT_LD;
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                     end
                     OP_DIV, OP_DIVU: begin
                        op_q    <= mduOp;
                        a_q     <= srcA;
                        b_q     <= srcB;
                        cnt_q   <= DIV_LD;
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                     end
                     OP_MTHI: hi_q <= srcA;
                     OP_MTLO: lo_q <= srcA;
                     default: ;
                  endcase
               end
            end
            RUN: begin
               if (cnt_q == '0) begin
                  hi_q    <= hi_d;
                  lo_q    <= lo_d;
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Stall the pipeline for a multi-cycle request or while busy.
   always_comb begin
      stall = (start && (mduOp >= OP_MULT) && (mduOp <= OP_DIVU))
              || busy_q;
   end

   assign busy = busy_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit.
// Stimulus queues expected HI/LO; a monitor checks at completion.
module tb_mult_div_unit;

   logic        clk;
   logic        reset_n;
   logic [31:0] srcA;
   logic [31:0] srcB;
   logic [2:0]  mduOp;
   logic        start;
   logic        busy;
   logic        stall;
   logic [31:0] hi;
   logic [31:0] lo;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          n;
      string       name;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   fails  = 0;

   mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .srcA   (srcA),
      .srcB   (srcB),
      .mduOp  (mduOp),
      .start  (start),
      .busy   (busy),
      .stall  (stall),
      .hi     (hi),
      .lo     (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic push(input string nm, input logic [31:0] h,
                       input logic [31:0] l, input int n);
      exp_t e;
      e.hi = h;
      e.lo = l;
      e.n = n;
      e.name = nm;
      q.push_back(e);
   endtask

   // Waits (bounded) for idle, then drives a one-cycle start.
   task automatic issue(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b);
      int g;
      logic exp_st;
      g = 0;
      while (busy === 1'b1 && g < 100) begin
         @(posedge clk);
         #1;
         g++;
      end
      if (busy !== 1'b0) begin
         fails++;
         checks++;
         $display("FAIL idle_wait: busy stuck at %b", busy);
      end
      mduOp = op;
      srcA  = a;
      srcB  = b;
      start = 1'b1;
      exp_st = (op >= 3'd1 && op <= 3'd4);
      #1;
      chk("stall_start", {31'd0, stall}, {31'd0, exp_st});
      @(posedge clk);
      #1;
      start = 1'b0;
      mduOp = 3'd0;
      srcA  = 32'hDEAD_BEEF;
      srcB  = 32'h0000_0001;
   endtask

   task automatic wait_done();
      int g;
      g = 0;
      while (busy === 1'b1 && g < 100) begin
         @(posedge clk);
         #1;
         g++;
      end
      if (busy !== 1'b0) begin
         fails++;
         checks++;
         $display("FAIL done_wait: busy stuck at %b", busy);
      end
   endtask

   // Monitor: on every busy falling edge compare HI/LO and busy length.
   initial begin : monitor
      logic prev;
      int   bc;
      exp_t e;
      prev = 1'b0;
      bc   = 0;
      forever begin
         @(negedge clk);
         if (reset_n !== 1'b1) begin
            prev = 1'b0;
            bc   = 0;
         end else begin
            if (busy === 1'b1) bc++;
            if (prev && busy === 1'b0) begin
               if (q.size() == 0) begin
                  fails++;
                  checks++;
                  $display("FAIL unexpected_done: hi %h lo %h", hi, lo);
               end else begin
                  e = q.pop_front();
                  chk({e.name, "_hi"}, hi, e.hi);
                  chk({e.name, "_lo"}, lo, e.lo);
                  chk({e.name, "_cycles"}, 32'(bc), 32'(e.n));
               end
               bc = 0;
            end
            prev = busy;
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation timed out");
      $fatal(1);
   end

   initial begin : stim
      int stall_cnt;
      reset_n = 1'b0;
      start   = 1'b0;
      mduOp   = 3'd0;
      srcA    = 32'd0;
      srcB    = 32'd0;
      #2;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_hi", hi, 32'd0);
      chk("rst_lo", lo, 32'd0);
      chk("rst_stall", {31'd0, stall}, 32'd0);
      #10;
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      push("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
      issue(3'd1, 32'hFFFF_FFFE, 32'd3);
      chk("mult_busy1", {31'd0, busy}, 32'd1);
      chk("mult_hold_hi", hi, 32'd0);

      push("multu_max", 32'hFFFF_FFFE, 32'h0000_0001, 5);
      issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

      push("mult_min2", 32'h4000_0000, 32'h0000_0000, 5);
      issue(3'd1, 32'h8000_0000, 32'h8000_0000);

      push("multu_max2", 32'hFFFF_FFFE, 32'h0000_0001, 5);
      issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

      push("div_m7_2", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
      issue(3'd3, 32'hFFFF_FFF9, 32'd2);
      @(posedge clk);
      #1;
      mduOp = 3'd5;
      srcA  = 32'h5555_5555;
      start = 1'b1;
      #1;
      chk("mthi_busy_stall", {31'd0, stall}, 32'd1);
      @(posedge clk);
      #1;
      start = 1'b0;
      mduOp = 3'd0;
      chk("mthi_busy_ign", hi, 32'hFFFF_FFFE);
      wait_done();

      push("divu_by0", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
      issue(3'd4, 32'd7, 32'd0);

      push("div_7_m2", 32'h0000_0001, 32'hFFFF_FFFD, 10);
      issue(3'd3, 32'd7, 32'hFFFF_FFFE);

      push("divu_100_7", 32'h0000_0002, 32'h0000_000E, 10);
      issue(3'd4, 32'd100, 32'd7);

      push("div_ovf", 32'h0000_0000, 32'h8000_0000, 10);
      issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
      stall_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         if (stall === 1'b1) stall_cnt++;
         @(posedge clk);
         #1;
      end
      chk("div_ovf_stall", 32'(stall_cnt), 32'd10);
      chk("div_ovf_idle", {31'd0, busy}, 32'd0);

      issue(3'd0, 32'h1111_1111, 32'd1);
      issue(3'd7, 32'h2222_2222, 32'd1);
      mduOp = 3'd1;
      srcA  = 32'd9;
      srcB  = 32'd9;
      @(posedge clk);
      #1;
      mduOp = 3'd0;
      chk("nop_busy", {31'd0, busy}, 32'd0);
      chk("nop_hi", hi, 32'h0000_0000);
      chk("nop_lo", lo, 32'h8000_0000);

      issue(3'd5, 32'h1234_5678, 32'd0);
      chk("mthi_busy", {31'd0, busy}, 32'd0);
      issue(3'd6, 32'h9ABC_DEF0, 32'd0);
      chk("mtlo_busy", {31'd0, busy}, 32'd0);
      chk("mt_hi", hi, 32'h1234_5678);
      chk("mt_lo", lo, 32'h9ABC_DEF0);

      issue(3'd1, 32'd100, 32'd200);
      @(posedge clk);
      @(posedge clk);
      #3;
      reset_n = 1'b0;
      #1;
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_hi", hi, 32'd0);
      chk("abort_lo", lo, 32'd0);
      #9;
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      repeat (10) @(posedge clk);
      #1;
      chk("abort_busy2", {31'd0, busy}, 32'd0);
      chk("abort_hi2", hi, 32'd0);
      chk("abort_lo2", lo, 32'd0);

      #2;
      reset_n = 1'b0;
      #5;
      reset_n = 1'b1;
      push("post_rst", 32'd0, 32'h0000_000C, 5);
      issue(3'd2, 32'd3, 32'd4);
      chk("post_rst_busy", {31'd0, busy}, 32'd1);
      wait_done();

      repeat (2) @(posedge clk);
      #1;
      chk("queue_empty", 32'(q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
